// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lcd_pkg                                                          |
// | Brief    : Shared widths, blank code and arbiter state encoding.            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package lcd_pkg;

    localparam int         ADDR_W    = 5;
    localparam int         DATA_W    = 8;
    localparam logic [7:0] LCD_BLANK = 8'h80;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_write_arbiter_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_picker                                                        |
// | Brief    : Combinational rotate-priority encoder starting the scan at ptr.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   winner
);

    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W:0]     w_sum;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign w_rot = NUM_REQ'({req, req} >> ptr);
    assign valid = |req;

    always_comb begin
        winner = '0;
        w_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (PTR_W + 1)'(k);
                if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                    w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
                end
                winner = w_sum[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lcd_write_arbiter                                                |
// | Brief    : Round-robin burst arbiter for the LCD register-file write port.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = lcd_pkg::ADDR_W,
    parameter int DATA_W    = lcd_pkg::DATA_W,
    parameter int MAX_BURST = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] reqCode,
    input  logic [NUM_REQ-1:0]        reqLast,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         characterCode,
    output logic                      wrEn,
    output logic                      busy,
    output logic                      errorLed
);

    import lcd_pkg::*;

    localparam int c_ptrW  = $clog2(NUM_REQ);
    localparam int c_beatW = $clog2(MAX_BURST + 1);
    localparam int c_idleW = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [c_ptrW-1:0]   r_ptr;
    logic [c_ptrW-1:0]   r_win;
    logic [c_ptrW-1:0]   w_pickIdx;
    logic [c_ptrW-1:0]   w_winInc;
    logic                w_pickValid;
    logic                w_grab;
    logic                w_accept;
    logic                w_release;
    logic                w_error;
    logic                w_hitMax;
    logic                w_timeout;
    logic [c_beatW-1:0]  r_beatCnt;
    logic [c_beatW-1:0]  w_beatNext;
    logic [c_idleW-1:0]  r_idleCnt;
    logic [c_idleW-1:0]  w_idleNext;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_code;
    logic                r_wrEn;
    logic                r_errorLed;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptrW)
    ) u_picker (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_pickValid),
        .winner (w_pickIdx)
    );

    assign w_grab     = (r_state == ST_IDLE) && w_pickValid;
    assign w_accept   = (r_state == ST_BURST) && req[r_win] && r_gnt[r_win];
    assign w_winInc   = (r_win == c_ptrW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
    assign w_beatNext = r_beatCnt + 1'b1;
    assign w_hitMax   = (w_beatNext == c_beatW'(MAX_BURST));
    assign w_idleNext = (r_idleCnt == c_idleW'(TIMEOUT)) ? r_idleCnt : r_idleCnt + 1'b1;
    assign w_timeout  = (w_idleNext == c_idleW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A last-flagged beat always releases cleanly, even when it is also beat MAX_BURST.
    always_comb begin
        w_nextState = r_state;
        w_release   = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pickValid) begin
                    w_nextState = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    if (reqLast[r_win]) begin
                        w_release = 1'b1;
                    end else if (w_hitMax) begin
                        w_release = 1'b1;
                        w_error   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_release = 1'b1;
                    w_error   = 1'b1;
                end
                if (w_release) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_win      <= '0;
            r_gnt      <= '0;
            r_beatCnt  <= '0;
            r_idleCnt  <= '0;
            r_addr     <= '0;
            r_code     <= '0;
            r_wrEn     <= 1'b0;
            r_errorLed <= 1'b0;
        end else begin
            r_wrEn <= w_accept;
            if (w_accept) begin
                r_addr <= reqAddr[r_win*ADDR_W +: ADDR_W];
                r_code <= reqCode[r_win*DATA_W +: DATA_W];
            end
            if (w_grab) begin
                r_gnt     <= NUM_REQ'(1) << w_pickIdx;
                r_win     <= w_pickIdx;
                r_beatCnt <= '0;
                r_idleCnt <= '0;
            end else if (r_state == ST_BURST) begin
                if (w_release) begin
                    r_gnt <= '0;
                    r_ptr <= w_winInc;
                end
                if (w_accept) begin
                    r_beatCnt <= w_beatNext;
                    r_idleCnt <= '0;
                end else begin
                    r_idleCnt <= w_idleNext;
                end
            end
            if (w_error) begin
                r_errorLed <= 1'b1;
            end
        end
    end

    assign gnt           = r_gnt;
    assign addr          = r_addr;
    assign characterCode = r_code;
    assign wrEn          = r_wrEn;
    assign busy          = (r_state == ST_BURST);
    assign errorLed      = r_errorLed;

endmodule
`default_nettype wire
